open_list_pqueue: RTL and testbench

- Parametrised successor to the A* open-list queue: a fully sorted, register-based min-priority queue of (f, i, j) nodes, with the lowest f at the head.
- Supports insert, pop-min, and simultaneous insert+pop in a single cycle.
- Adds tie ordering, occupancy count, error flags and an optional decrease-key merge on matching (i,j).
- Sits between the A* expansion logic (inserts neighbours) and the node selector (pops the best node).

---
 rtl/open_list_pqueue.sv | 149 ++++++++++++++
 tb/tb_open_list_pqueue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/open_list_pqueue.sv
// Fully sorted register-based min-priority open list of (f,i,j) nodes for A*.
// Optional decrease-key merge on matching (i,j) is enabled by OLQ_DECREASE_KEY_EN.
module open_list_pqueue #(
    parameter int QUEUE_SIZE = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAP_WIDTH  = 16,
    parameter int MAP_HEIGHT = 16
) (
    input  logic                            CLK,
    input  logic                            RSTn,
    input  logic                            i_wrt,
    input  logic                            i_read,
    input  logic [DATA_WIDTH-1:0]           i_node_f,
    input  logic [MAP_WIDTH-1:0]            i_node_i,
    input  logic [MAP_HEIGHT-1:0]           i_node_j,
    output logic                            o_empty,
    output logic                            o_full,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
    output logic                            o_valid,
    output logic [DATA_WIDTH-1:0]           o_node_f,
    output logic [MAP_WIDTH-1:0]            o_node_i,
    output logic [MAP_HEIGHT-1:0]           o_node_j,
    output logic                            o_dup,
    output logic                            o_err
);
    localparam int CW = $clog2(QUEUE_SIZE+1);
`ifdef OLQ_DECREASE_KEY_EN
    localparam int IW = $clog2(QUEUE_SIZE);
`endif

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] f;
        logic [MAP_WIDTH-1:0]  i;
        logic [MAP_HEIGHT-1:0] j;
    } entry_t;

    entry_t          r_q [QUEUE_SIZE];
    logic [CW-1:0]   r_count;
    logic            r_empty, r_full, r_valid, r_dup, r_err;
    logic [DATA_WIDTH-1:0] r_node_f;
    logic [MAP_WIDTH-1:0]  r_node_i;
    logic [MAP_HEIGHT-1:0] r_node_j;

    entry_t          w_b [QUEUE_SIZE];   // after pop
    entry_t          w_c [QUEUE_SIZE];   // after decrease-key removal
    entry_t          w_n [QUEUE_SIZE];   // after insert
    entry_t          w_new;
    logic            w_pop, w_ins, w_room, w_err, w_remove, w_drop;
    logic [CW-1:0]   w_pos, w_cnt_n;
`ifdef OLQ_DECREASE_KEY_EN
    logic            w_hit, w_better;
    logic [IW-1:0]   w_hit_idx;
`endif

    always_comb begin
        w_pop = i_read && !r_empty;
        for (int k = 0; k < QUEUE_SIZE-1; k++)
            w_b[k] = w_pop ? r_q[k+1] : r_q[k];
        w_b[QUEUE_SIZE-1] = w_pop ? '0 : r_q[QUEUE_SIZE-1];

        // The entry leaving this cycle is already gone from w_b, so it never matches.
`ifdef OLQ_DECREASE_KEY_EN
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = 0; k < QUEUE_SIZE; k++) begin
            if (!w_hit && w_b[k].vld && w_b[k].i == i_node_i && w_b[k].j == i_node_j) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(k);
            end
        end
        w_better = w_hit && (i_node_f < w_b[w_hit_idx].f);
        w_remove = i_wrt && w_better;
        w_drop   = i_wrt && w_hit && !w_better;
        for (int k = 0; k < QUEUE_SIZE-1; k++)
            w_c[k] = (w_remove && IW'(k) >= w_hit_idx) ? w_b[k+1] : w_b[k];
        w_c[QUEUE_SIZE-1] = w_remove ? '0 : w_b[QUEUE_SIZE-1];
`else
        w_remove = 1'b0;
        w_drop   = 1'b0;
        for (int k = 0; k < QUEUE_SIZE; k++)
            w_c[k] = w_b[k];
`endif

        w_room = w_pop || !r_full || w_remove;
        w_ins  = i_wrt && !w_drop && w_room;
        w_err  = (i_read && r_empty) || (i_wrt && !w_drop && !w_room);

        // Counting "<=" places the new node behind all equal-f entries.
        w_pos = '0;
        for (int k = 0; k < QUEUE_SIZE; k++)
            if (w_c[k].vld && w_c[k].f <= i_node_f)
                w_pos = w_pos + CW'(1);

        w_new = '{vld: 1'b1, f: i_node_f, i: i_node_i, j: i_node_j};
        w_n[0] = (w_ins && w_pos == '0) ? w_new : w_c[0];
        for (int k = 1; k < QUEUE_SIZE; k++) begin
            if (!w_ins || CW'(k) < w_pos)
                w_n[k] = w_c[k];
            else if (CW'(k) == w_pos)
                w_n[k] = w_new;
            else
                w_n[k] = w_c[k-1];
        end

        w_cnt_n = r_count + CW'(w_ins) - CW'(w_pop) - CW'(w_remove);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int k = 0; k < QUEUE_SIZE; k++)
                r_q[k] <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
            r_dup    <= 1'b0;
            r_err    <= 1'b0;
            r_node_f <= '0;
            r_node_i <= '0;
            r_node_j <= '0;
        end else begin
            for (int k = 0; k < QUEUE_SIZE; k++)
                r_q[k] <= w_n[k];
            r_count <= w_cnt_n;
            r_empty <= (w_cnt_n == '0);
            r_full  <= (w_cnt_n == CW'(QUEUE_SIZE));
            r_valid <= w_pop;
            r_dup   <= w_remove || w_drop;
            r_err   <= w_err;
            if (w_pop) begin
                r_node_f <= r_q[0].f;
                r_node_i <= r_q[0].i;
                r_node_j <= r_q[0].j;
            end
        end
    end

    assign o_count  = r_count;
    assign o_empty  = r_empty;
    assign o_full   = r_full;
    assign o_valid  = r_valid;
    assign o_dup    = r_dup;
    assign o_err    = r_err;
    assign o_node_f = r_node_f;
    assign o_node_i = r_node_i;
    assign o_node_j = r_node_j;

endmodule

// File: tb/tb_open_list_pqueue.sv
// Bench for open_list_pqueue: directed scenarios plus random ops against a queue-based model.
module tb_open_list_pqueue;
    localparam int Q  = 16;
    localparam int DW = 32;
    localparam int MW = 16;
    localparam int MH = 16;
    localparam int CW = $clog2(Q+1);
    localparam int VW = 5 + CW + DW + MW + MH;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          i_wrt, i_read;
    logic [DW-1:0] i_node_f;
    logic [MW-1:0] i_node_i;
    logic [MH-1:0] i_node_j;
    logic          o_empty, o_full, o_valid, o_dup, o_err;
    logic [CW-1:0] o_count;
    logic [DW-1:0] o_node_f;
    logic [MW-1:0] o_node_i;
    logic [MH-1:0] o_node_j;

    open_list_pqueue #(.QUEUE_SIZE(Q), .DATA_WIDTH(DW), .MAP_WIDTH(MW), .MAP_HEIGHT(MH)) dut (
        .CLK(CLK), .RSTn(RSTn), .i_wrt(i_wrt), .i_read(i_read),
        .i_node_f(i_node_f), .i_node_i(i_node_i), .i_node_j(i_node_j),
        .o_empty(o_empty), .o_full(o_full), .o_count(o_count), .o_valid(o_valid),
        .o_node_f(o_node_f), .o_node_i(o_node_i), .o_node_j(o_node_j),
        .o_dup(o_dup), .o_err(o_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] f;
        logic [MW-1:0] i;
        logic [MH-1:0] j;
    } node_t;

    node_t         mq[$];
    logic [DW-1:0] lf;
    logic [MW-1:0] li;
    logic [MH-1:0] lj;
    logic [VW-1:0] exp_v;
    int            total = 0;
    int            bad = 0;

    function automatic logic [VW-1:0] obs();
        return {o_valid, o_err, o_dup, o_empty, o_full, o_count, o_node_f, o_node_i, o_node_j};
    endfunction

    task automatic model_clear();
        mq.delete();
        lf = '0; li = '0; lj = '0;
    endtask

    // Drive one cycle and advance the model; exp_v holds the expected post-edge outputs.
    task automatic op(input logic w, input logic r, input logic [DW-1:0] f,
                      input logic [MW-1:0] i, input logic [MH-1:0] j);
        logic  valid, err, dup, doins;
        node_t t;
        int    p;
        valid = 0; err = 0; dup = 0; doins = w;
        i_wrt = w; i_read = r; i_node_f = f; i_node_i = i; i_node_j = j;
        if (r) begin
            if (mq.size() == 0) err = 1;
            else begin
                t = mq.pop_front();
                valid = 1; lf = t.f; li = t.i; lj = t.j;
            end
        end
`ifdef OLQ_DECREASE_KEY_EN
        if (w) begin
            p = -1;
            for (int k = 0; k < mq.size(); k++)
                if (p < 0 && mq[k].i == i && mq[k].j == j) p = k;
            if (p >= 0) begin
                dup = 1;
                if (f < mq[p].f) mq.delete(p);
                else doins = 0;
            end
        end
`endif
        if (doins) begin
            if (mq.size() >= Q) err = 1;
            else begin
                t.f = f; t.i = i; t.j = j;
                p = 0;
                while (p < mq.size() && mq[p].f <= f) p++;
                mq.insert(p, t);
            end
        end
        exp_v = {valid, err, dup, mq.size() == 0, mq.size() == Q, CW'(mq.size()), lf, li, lj};
        @(posedge CLK);
        #1;
        i_wrt = 0; i_read = 0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] want;
        want = '0;
        want[VW-4] = 1'b1;
        RSTn = 0; i_wrt = 0; i_read = 0; i_node_f = 0; i_node_i = 0; i_node_j = 0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        if (obs() !== want) begin bad++; $display("FAIL reset got=%h want=%h", obs(), want); end
        total++;
        RSTn = 1;
        @(posedge CLK); #1;
    endtask

    task automatic test_sorted();
        logic [DW-1:0] fin [6] = '{12, 1, 2, 14, 12, 3};
        logic [MW-1:0] cin [6] = '{5, 3, 1, 6, 4, 2};
        logic [DW-1:0] fout [6] = '{1, 2, 3, 12, 12, 14};
        logic [MW-1:0] iout [6] = '{3, 1, 2, 5, 4, 6};
        for (int k = 0; k < 6; k++) op(1, 0, fin[k], cin[k], cin[k]);
        if (o_count !== CW'(6)) begin bad++; $display("FAIL sorted_count got=%0d want=6", o_count); end
        total++;
        for (int k = 0; k < 6; k++) begin
            op(0, 1, 0, 0, 0);
            if (o_valid !== 1'b1 || o_node_f !== fout[k] || o_node_i !== iout[k]) begin
                bad++;
                $display("FAIL sorted_pop%0d got v=%b f=%0d i=%0d want v=1 f=%0d i=%0d",
                         k, o_valid, o_node_f, o_node_i, fout[k], iout[k]);
            end
            total++;
        end
        if (o_empty !== 1'b1 || obs() !== exp_v) begin bad++; $display("FAIL sorted_empty got=%h want=%h", obs(), exp_v); end
        total++;
    endtask

    task automatic test_overflow();
        for (int k = 0; k < Q; k++) op(1, 0, DW'(20 + k), MW'(k), MH'(k));
        if (o_full !== 1'b1 || obs() !== exp_v) begin bad++; $display("FAIL fill got=%h want=%h", obs(), exp_v); end
        total++;
        op(1, 0, 7, 200, 200);
        if (o_err !== 1'b1 || o_count !== CW'(Q) || obs() !== exp_v) begin
            bad++; $display("FAIL overflow got=%h want=%h", obs(), exp_v);
        end
        total++;
        op(1, 1, 0, 201, 201);
        if (o_valid !== 1'b1 || o_node_f !== 32'd20 || o_count !== CW'(Q) || obs() !== exp_v) begin
            bad++; $display("FAIL full_swap got=%h want=%h", obs(), exp_v);
        end
        total++;
        op(0, 1, 0, 0, 0);
        if (o_node_f !== 32'd0 || obs() !== exp_v) begin bad++; $display("FAIL full_newhead got=%h want=%h", obs(), exp_v); end
        total++;
        while (mq.size() > 0) op(0, 1, 0, 0, 0);
        if (obs() !== exp_v) begin bad++; $display("FAIL drain got=%h want=%h", obs(), exp_v); end
        total++;
    endtask

    task automatic test_underflow();
        op(0, 1, 0, 0, 0);
        if (o_err !== 1'b1 || o_valid !== 1'b0 || o_count !== '0 || obs() !== exp_v) begin
            bad++; $display("FAIL underflow got=%h want=%h", obs(), exp_v);
        end
        total++;
        op(1, 1, 9, 7, 7);
        if (o_err !== 1'b1 || o_count !== CW'(1) || obs() !== exp_v) begin
            bad++; $display("FAIL underflow_ins got=%h want=%h", obs(), exp_v);
        end
        total++;
        op(0, 1, 0, 0, 0);
        if (o_node_f !== 32'd9 || o_valid !== 1'b1 || obs() !== exp_v) begin
            bad++; $display("FAIL underflow_pop got=%h want=%h", obs(), exp_v);
        end
        total++;
    endtask

    task automatic test_head_replace();
        op(1, 0, 4, 1, 1);
        op(1, 0, 8, 2, 2);
        op(1, 1, 2, 3, 3);
        if (o_node_f !== 32'd4 || o_count !== CW'(2) || obs() !== exp_v) begin
            bad++; $display("FAIL head_swap got=%h want=%h", obs(), exp_v);
        end
        total++;
        op(0, 1, 0, 0, 0);
        if (o_node_f !== 32'd2 || obs() !== exp_v) begin bad++; $display("FAIL head_new got=%h want=%h", obs(), exp_v); end
        total++;
        op(0, 1, 0, 0, 0);
        if (o_node_f !== 32'd8 || o_empty !== 1'b1) begin bad++; $display("FAIL head_last got f=%0d e=%b want f=8 e=1", o_node_f, o_empty); end
        total++;
    endtask

`ifdef OLQ_DECREASE_KEY_EN
    task automatic test_decrease_key();
        op(1, 0, 10, 3, 3);
        op(1, 0, 6, 3, 3);
        if (o_dup !== 1'b1 || o_count !== CW'(1) || obs() !== exp_v) begin
            bad++; $display("FAIL dk_merge got=%h want=%h", obs(), exp_v);
        end
        total++;
        op(0, 1, 0, 0, 0);
        if (o_node_f !== 32'd6 || obs() !== exp_v) begin bad++; $display("FAIL dk_pop got=%h want=%h", obs(), exp_v); end
        total++;
        op(1, 0, 9, 1, 1);
        op(1, 0, 11, 1, 1);
        if (o_dup !== 1'b1 || o_count !== CW'(1) || obs() !== exp_v) begin
            bad++; $display("FAIL dk_drop got=%h want=%h", obs(), exp_v);
        end
        total++;
        op(0, 1, 0, 0, 0);
        if (o_node_f !== 32'd9 || obs() !== exp_v) begin bad++; $display("FAIL dk_drop_pop got=%h want=%h", obs(), exp_v); end
        total++;
    endtask
`endif

    task automatic test_random();
        logic w, r;
        for (int n = 0; n < 600; n++) begin
            w = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 4);
            op(w, r, DW'($urandom_range(0, 15)), MW'($urandom_range(0, 3)), MH'($urandom_range(0, 3)));
            if (obs() !== exp_v) begin bad++; $display("FAIL random%0d got=%h want=%h", n, obs(), exp_v); end
            total++;
        end
        while (mq.size() > 0) op(0, 1, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 5; k++) op(1, 0, DW'(30 + k), MW'(50 + k), MH'(k));
        #2;
        RSTn = 0;
        #1;
        if (o_empty !== 1'b1 || o_count !== '0 || o_valid !== 1'b0) begin
            bad++; $display("FAIL async_reset got e=%b c=%0d v=%b want e=1 c=0 v=0", o_empty, o_count, o_valid);
        end
        total++;
        model_clear();
        @(posedge CLK); #2;
        RSTn = 1;
        @(posedge CLK); #1;
        op(1, 0, 3, 9, 9);
        op(0, 1, 0, 0, 0);
        if (o_node_f !== 32'd3 || o_valid !== 1'b1 || obs() !== exp_v) begin
            bad++; $display("FAIL post_reset got=%h want=%h", obs(), exp_v);
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_sorted();
        test_overflow();
        test_underflow();
        test_head_replace();
`ifdef OLQ_DECREASE_KEY_EN
        test_decrease_key();
`endif
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
